// File: rtl/ag32gbd_block_fill.sv
// ag32gbd_block_fill
//   Front end of the SRAM bank0 writer. Packs 2bpp raster pixels (ROW_PIXELS per row) into
//   BLOCK_ROWS-row blocks, four pixels per byte with the leftmost pixel in bits [7:6].
//   Two banks form a ping-pong pair: one fills while the writer reads the other.
//
// Ports
//   sys_clock            clock
//   sys_reset            synchronous active-high reset
//   NewRunReset          synchronous frame-start clear, same effect as sys_reset
//   Pixel_Valid          one pixel accepted per cycle when high
//   Pixel_Value[1:0]     2bpp pixel (3 = darkest)
//   Test_Pattern_Select  selects the test pattern (only with AG32GBD_TEST_PATTERN_EN)
//   Gbd_Writing_Ram      writer busy
//   RequestReadBuffer    read strobe from writer
//   ReadBufferOffset     byte offset in the presented bank ([9:8] must be 0)
//   BufferReadResult     read data, registered, valid the cycle after the strobe
//   BlockBufferDataReady a completed block is presented to the writer
//   Frame_Done           1-cycle pulse when the last block of a frame is presented
//   Block_Overflow       sticky: a completed block was dropped
//
// Configuration
//   AG32GBD_TEST_PATTERN_EN: when defined and Test_Pattern_Select=1, the packed pixel is x[4:3]
//   (8-pixel-wide vertical bars). When undefined, Test_Pattern_Select is ignored.
module ag32gbd_block_fill #(
    parameter int unsigned ROW_PIXELS       = 128,
    parameter int unsigned BLOCK_ROWS       = 8,
    parameter int unsigned BLOCKS_PER_FRAME = 16
) (
    input  logic       sys_clock,
    input  logic       sys_reset,
    input  logic       NewRunReset,
    input  logic       Pixel_Valid,
    input  logic [1:0] Pixel_Value,
    input  logic       Test_Pattern_Select,
    input  logic       Gbd_Writing_Ram,
    input  logic       RequestReadBuffer,
    input  logic [9:0] ReadBufferOffset,
    output logic [7:0] BufferReadResult,
    output logic       BlockBufferDataReady,
    output logic       Frame_Done,
    output logic       Block_Overflow
);

    localparam int unsigned XW        = $clog2(ROW_PIXELS);
    localparam int unsigned YW        = $clog2(BLOCK_ROWS);
    localparam int unsigned BW        = $clog2(BLOCKS_PER_FRAME);
    localparam int unsigned BankBytes = ROW_PIXELS / 4 * BLOCK_ROWS;
    localparam int unsigned AW        = $clog2(BankBytes);
    localparam int unsigned Depth     = 2 * BankBytes;

    localparam logic [XW-1:0] XLast = XW'(ROW_PIXELS - 1);
    localparam logic [YW-1:0] YLast = YW'(BLOCK_ROWS - 1);
    localparam logic [BW-1:0] BLast = BW'(BLOCKS_PER_FRAME - 1);

    typedef enum logic [2:0] {
        StIdle    = 3'b001,
        StPresent = 3'b010,
        StBusy    = 3'b100
    } state_e;

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [BW-1:0] block_q, block_d;
    logic [5:0]    pack_q, pack_d;
    logic          fill_bank_q, fill_bank_d;
    logic          ready_q, ready_d;
    logic          frame_done_q, frame_done_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    rdata_q, rdata_d;

    logic          clear;
    logic [1:0]    pix;
    logic          last_x, last_y, last_block;
    logic          byte_done, block_done, bank_free;
    logic          wr_en;
    logic [AW:0]   wr_addr, rd_addr;
    logic [7:0]    wr_byte;

    logic [7:0]    mem [Depth];

    assign clear = sys_reset | NewRunReset;

`ifdef AG32GBD_TEST_PATTERN_EN
    assign pix = Test_Pattern_Select ? x_q[4:3] : Pixel_Value;
    logic unused_inputs;
    assign unused_inputs = ^ReadBufferOffset[9:AW];
`else
    assign pix = Pixel_Value;
    logic unused_inputs;
    assign unused_inputs = ^{Test_Pattern_Select, ReadBufferOffset[9:AW]};
`endif

    assign last_x     = (x_q == XLast);
    assign last_y     = (y_q == YLast);
    assign last_block = (block_q == BLast);
    assign byte_done  = Pixel_Valid && (x_q[1:0] == 2'd3);
    assign block_done = Pixel_Valid && last_x && last_y;

    // The completing pixel goes straight into the byte; the pack register holds the 3 before it.
    assign wr_byte = {pack_q, pix};
    assign wr_addr = {fill_bank_q, y_q, x_q[XW-1:2]};
    // The presented bank is always the one not being filled, so reads never see a partial block.
    assign rd_addr = {~fill_bank_q, ReadBufferOffset[AW-1:0]};
    assign wr_en   = byte_done & ~clear;

    // Position counters and pixel packing.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        block_d = block_q;
        pack_d  = pack_q;
        if (Pixel_Valid) begin
            pack_d = {pack_q[3:0], pix};
            x_d    = last_x ? '0 : x_q + XW'(1);
            if (last_x) begin
                y_d = last_y ? '0 : y_q + YW'(1);
            end
            if (block_done) begin
                block_d = last_block ? '0 : block_q + BW'(1);
            end
        end
    end

    // Handoff FSM. A release in the same cycle as a completion frees the bank first.
    always_comb begin
        state_d      = state_q;
        ready_d      = ready_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        fill_bank_d  = fill_bank_q;
        bank_free    = 1'b0;
        unique case (state_q)
            StIdle: begin
                bank_free = 1'b1;
            end
            StPresent: begin
                if (Gbd_Writing_Ram) begin
                    ready_d = 1'b0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (!Gbd_Writing_Ram) begin
                    bank_free = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (block_done) begin
            if (bank_free) begin
                fill_bank_d  = ~fill_bank_q;
                ready_d      = 1'b1;
                state_d      = StPresent;
                frame_done_d = last_block;
            end else begin
                // Dropped: the fill bank is reused by the next block.
                overflow_d = 1'b1;
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (RequestReadBuffer) begin
            rdata_d = mem[rd_addr];
        end
    end

    always_ff @(posedge sys_clock) begin
        if (clear) begin
            state_q      <= StIdle;
            x_q          <= '0;
            y_q          <= '0;
            block_q      <= '0;
            pack_q       <= '0;
            fill_bank_q  <= 1'b0;
            ready_q      <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            block_q      <= block_d;
            pack_q       <= pack_d;
            fill_bank_q  <= fill_bank_d;
            ready_q      <= ready_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            rdata_q      <= rdata_d;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_byte;
        end
    end

    assign BufferReadResult     = rdata_q;
    assign BlockBufferDataReady = ready_q;
    assign Frame_Done           = frame_done_q;
    assign Block_Overflow       = overflow_q;

endmodule

// File: tb/tb_ag32gbd_block_fill.sv
// Bench for ag32gbd_block_fill: random pixel streams checked against a frame-level model that
// keeps the current block as a pixel image and packs it into bytes when it is handed off.
module tb_ag32gbd_block_fill;

    logic       sys_clock = 1'b0;
    logic       sys_reset, NewRunReset, Pixel_Valid, Test_Pattern_Select;
    logic       Gbd_Writing_Ram, RequestReadBuffer;
    logic [1:0] Pixel_Value;
    logic [9:0] ReadBufferOffset;
    logic [7:0] BufferReadResult;
    logic       BlockBufferDataReady, Frame_Done, Block_Overflow;

    ag32gbd_block_fill dut (
        .sys_clock            (sys_clock),
        .sys_reset            (sys_reset),
        .NewRunReset          (NewRunReset),
        .Pixel_Valid          (Pixel_Valid),
        .Pixel_Value          (Pixel_Value),
        .Test_Pattern_Select  (Test_Pattern_Select),
        .Gbd_Writing_Ram      (Gbd_Writing_Ram),
        .RequestReadBuffer    (RequestReadBuffer),
        .ReadBufferOffset     (ReadBufferOffset),
        .BufferReadResult     (BufferReadResult),
        .BlockBufferDataReady (BlockBufferDataReady),
        .Frame_Done           (Frame_Done),
        .Block_Overflow       (Block_Overflow)
    );

    always #5 sys_clock = ~sys_clock;

    int n_tests = 0;
    int n_fail  = 0;
    int fd_seen = 0;

    // Model: pixel image of the block being filled, bytes of the presented block, writer view.
    int         m_img [1024];
    logic [7:0] m_bank [256];
    int         m_pos, m_blk, m_wr;  // m_wr: 0 nothing presented, 1 presented, 2 writer busy
    bit         m_ready, m_ovf, m_fd;
    logic [7:0] m_rdata;

    function automatic logic [1:0] rnd2();
        return 2'($urandom_range(0, 3));
    endfunction

    task automatic model_reset();
        m_pos = 0; m_blk = 0; m_wr = 0;
        m_ready = 0; m_ovf = 0; m_fd = 0; m_rdata = 8'h00;
    endtask

    task automatic do_reset(input bit newrun);
        if (newrun) NewRunReset = 1'b1;
        else        sys_reset   = 1'b1;
        Pixel_Valid = 1'b0;
        @(posedge sys_clock); #1;
        NewRunReset = 1'b0;
        sys_reset   = 1'b0;
        model_reset();
    endtask

    // One clock: drive a pixel, then advance the model with what the DUT sampled.
    task automatic cycle(input bit valid, input logic [1:0] val);
        bit         done, free;
        int         v;
        logic [7:0] by;
        Pixel_Valid = valid;
        Pixel_Value = val;
        @(posedge sys_clock); #1;
        if (Frame_Done) fd_seen++;
        if (RequestReadBuffer) m_rdata = m_bank[ReadBufferOffset[7:0]];
        v = int'(val);
`ifdef AG32GBD_TEST_PATTERN_EN
        if (Test_Pattern_Select) v = ((m_pos % 128) / 8) % 4;
`endif
        done = valid && (m_pos == 1023);
        if (valid) m_img[m_pos] = v;
        free = (m_wr == 0) || (m_wr == 2 && !Gbd_Writing_Ram);
        if (m_wr == 1 && Gbd_Writing_Ram) begin
            m_wr = 2; m_ready = 0;
        end else if (m_wr == 2 && !Gbd_Writing_Ram) begin
            m_wr = 0;
        end
        m_fd = 0;
        if (done) begin
            if (free) begin
                for (int b = 0; b < 256; b++) begin
                    by = 8'h00;
                    for (int p = 0; p < 4; p++)
                        by = by | (8'(m_img[(b / 32) * 128 + (b % 32) * 4 + p]) << (6 - 2 * p));
                    m_bank[b] = by;
                end
                m_wr = 1; m_ready = 1; m_fd = (m_blk == 15);
            end else begin
                m_ovf = 1;
            end
            m_blk = (m_blk + 1) % 16;
            m_pos = 0;
        end else if (valid) begin
            m_pos++;
        end
        Pixel_Valid = 1'b0;
    endtask

    // Send n valid random pixels with random idle gaps; ends on the cycle of the last pixel.
    task automatic stream(input int n, input int gap_pct);
        int sent = 0;
        while (sent < n) begin
            if (int'($urandom_range(0, 99)) >= gap_pct) begin
                cycle(1'b1, rnd2());
                sent++;
            end else begin
                cycle(1'b0, rnd2());
            end
        end
    endtask

    task automatic test_reset();
        Gbd_Writing_Ram = 0; RequestReadBuffer = 0; ReadBufferOffset = '0;
        Test_Pattern_Select = 0; Pixel_Value = '0;
        do_reset(1'b0);
        n_tests++;
        if (BlockBufferDataReady !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 0", BlockBufferDataReady);
        end
        n_tests++;
        if (Block_Overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_overflow: got %b expected 0", Block_Overflow);
        end
        n_tests++;
        if (Frame_Done !== 1'b0) begin
            n_fail++; $display("FAIL reset_frame_done: got %b expected 0", Frame_Done);
        end
        n_tests++;
        if (BufferReadResult !== 8'h00) begin
            n_fail++; $display("FAIL reset_rdata: got %h expected 00", BufferReadResult);
        end
    endtask

    task automatic test_one_block();
        for (int i = 0; i < 1024; i++) begin
            cycle(1'b1, 2'(i % 4));
            if (i >= 1022) begin
                n_tests++;
                if (BlockBufferDataReady !== m_ready) begin
                    n_fail++;
                    $display("FAIL one_block_ready px%0d: got %b expected %b",
                             i, BlockBufferDataReady, m_ready);
                end
            end
        end
        n_tests++;
        if (Frame_Done !== m_fd) begin
            n_fail++; $display("FAIL one_block_frame_done: got %b expected %b", Frame_Done, m_fd);
        end
        for (int o = 0; o < 256; o++) begin
            RequestReadBuffer = 1; ReadBufferOffset = 10'(o);
            cycle(1'b0, 2'd0);
            n_tests++;
            if (BufferReadResult !== m_rdata || m_rdata !== 8'h1B) begin
                n_fail++;
                $display("FAIL one_block_read[%0d]: got %h expected %h", o, BufferReadResult, m_rdata);
            end
        end
        RequestReadBuffer = 0; ReadBufferOffset = 10'd77;
        cycle(1'b0, 2'd0);
        n_tests++;
        if (BufferReadResult !== m_rdata) begin
            n_fail++; $display("FAIL read_hold: got %h expected %h", BufferReadResult, m_rdata);
        end
    endtask

    task automatic test_handshake();
        int o;
        cycle(1'b0, 2'd0); cycle(1'b0, 2'd0);
        n_tests++;
        if (BlockBufferDataReady !== 1'b1) begin
            n_fail++; $display("FAIL hs_ready_held: got %b expected 1", BlockBufferDataReady);
        end
        Gbd_Writing_Ram = 1;
        cycle(1'b0, 2'd0);
        n_tests++;
        if (BlockBufferDataReady !== m_ready) begin
            n_fail++; $display("FAIL hs_ready_fall: got %b expected %b", BlockBufferDataReady, m_ready);
        end
        // Writer stays busy until the very cycle the next block completes.
        stream(1023, 20);
        Gbd_Writing_Ram = 0;
        cycle(1'b1, rnd2());
        n_tests++;
        if (BlockBufferDataReady !== m_ready || Block_Overflow !== m_ovf) begin
            n_fail++;
            $display("FAIL hs_same_cycle_release: got rdy=%b ovf=%b expected rdy=%b ovf=%b",
                     BlockBufferDataReady, Block_Overflow, m_ready, m_ovf);
        end
        Gbd_Writing_Ram = 1; cycle(1'b0, 2'd0);
        Gbd_Writing_Ram = 0; cycle(1'b0, 2'd0);
        stream(1024, 30);
        n_tests++;
        if (BlockBufferDataReady !== m_ready || Block_Overflow !== m_ovf) begin
            n_fail++;
            $display("FAIL hs_next_block: got rdy=%b ovf=%b expected rdy=%b ovf=%b",
                     BlockBufferDataReady, Block_Overflow, m_ready, m_ovf);
        end
        for (int k = 0; k < 24; k++) begin
            o = int'($urandom_range(0, 255));
            RequestReadBuffer = 1; ReadBufferOffset = 10'(o);
            cycle(1'b0, 2'd0);
            n_tests++;
            if (BufferReadResult !== m_rdata) begin
                n_fail++;
                $display("FAIL hs_read[%0d]: got %h expected %h", o, BufferReadResult, m_rdata);
            end
        end
        RequestReadBuffer = 0;
    endtask

    task automatic test_overflow();
        Gbd_Writing_Ram = 1;
        cycle(1'b0, 2'd0);
        for (int blk = 0; blk < 2; blk++) begin
            stream(1023, 10);
            n_tests++;
            if (Block_Overflow !== m_ovf) begin
                n_fail++; $display("FAIL ovf_before[%0d]: got %b expected %b", blk, Block_Overflow, m_ovf);
            end
            cycle(1'b1, rnd2());
            n_tests++;
            if (Block_Overflow !== m_ovf || BlockBufferDataReady !== m_ready) begin
                n_fail++;
                $display("FAIL ovf_after[%0d]: got ovf=%b rdy=%b expected ovf=%b rdy=%b",
                         blk, Block_Overflow, BlockBufferDataReady, m_ovf, m_ready);
            end
        end
        for (int o = 0; o < 256; o++) begin
            RequestReadBuffer = 1; ReadBufferOffset = 10'(o);
            cycle(1'b0, 2'd0);
            n_tests++;
            if (BufferReadResult !== m_rdata) begin
                n_fail++;
                $display("FAIL ovf_bank_kept[%0d]: got %h expected %h", o, BufferReadResult, m_rdata);
            end
        end
        RequestReadBuffer = 0;
        Gbd_Writing_Ram = 0;
        cycle(1'b0, 2'd0); cycle(1'b0, 2'd0);
        n_tests++;
        if (Block_Overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sticky: got %b expected 1", Block_Overflow);
        end
        do_reset(1'b0);
        n_tests++;
        if (Block_Overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_cleared: got %b expected 0", Block_Overflow);
        end
    endtask

    task automatic test_frame();
        Gbd_Writing_Ram = 0; RequestReadBuffer = 0;
        do_reset(1'b1);
        fd_seen = 0;
        for (int b = 0; b < 17; b++) begin
            stream(1024, 10);
            n_tests++;
            if (BlockBufferDataReady !== m_ready || Frame_Done !== m_fd) begin
                n_fail++;
                $display("FAIL frame_rise[%0d]: got rdy=%b fd=%b expected rdy=%b fd=%b",
                         b, BlockBufferDataReady, Frame_Done, m_ready, m_fd);
            end
            cycle(1'b0, 2'd0); cycle(1'b0, 2'd0);
            Gbd_Writing_Ram = 1; cycle(1'b0, 2'd0); cycle(1'b0, 2'd0);
            Gbd_Writing_Ram = 0; cycle(1'b0, 2'd0);
        end
        n_tests++;
        if (fd_seen !== 1) begin
            n_fail++; $display("FAIL frame_done_count: got %0d expected 1", fd_seen);
        end
        n_tests++;
        if (Block_Overflow !== m_ovf) begin
            n_fail++; $display("FAIL frame_no_overflow: got %b expected %b", Block_Overflow, m_ovf);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        Gbd_Writing_Ram = 0;
        stream(1024, 0);
        Gbd_Writing_Ram = 1;
        cycle(1'b0, 2'd0);
        stream(1024, 0);
        RequestReadBuffer = 1; ReadBufferOffset = 10'd5;
        cycle(1'b0, 2'd0);
        RequestReadBuffer = 0;
        stream(500, 0);
        Gbd_Writing_Ram = 0;
        do_reset(1'b1);
        n_tests++;
        if ({BlockBufferDataReady, Frame_Done, Block_Overflow, BufferReadResult} !== 11'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got rdy=%b fd=%b ovf=%b rd=%h expected all 0",
                     BlockBufferDataReady, Frame_Done, Block_Overflow, BufferReadResult);
        end
        stream(1023, 15);
        n_tests++;
        if (BlockBufferDataReady !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_early_ready: got %b expected 0", BlockBufferDataReady);
        end
        cycle(1'b1, rnd2());
        n_tests++;
        if (BlockBufferDataReady !== m_ready) begin
            n_fail++; $display("FAIL mid_reset_ready: got %b expected %b", BlockBufferDataReady, m_ready);
        end
        for (int o = 0; o < 256; o++) begin
            RequestReadBuffer = 1; ReadBufferOffset = 10'(o);
            cycle(1'b0, 2'd0);
            n_tests++;
            if (BufferReadResult !== m_rdata) begin
                n_fail++;
                $display("FAIL mid_reset_read[%0d]: got %h expected %h", o, BufferReadResult, m_rdata);
            end
        end
        RequestReadBuffer = 0;
    endtask

    task automatic test_pattern();
        do_reset(1'b0);
        Gbd_Writing_Ram = 0;
        Test_Pattern_Select = 1;
        stream(1024, 25);
        Test_Pattern_Select = 0;
        for (int o = 0; o < 40; o++) begin
            RequestReadBuffer = 1; ReadBufferOffset = 10'(o);
            cycle(1'b0, 2'd0);
            n_tests++;
            if (BufferReadResult !== m_rdata) begin
                n_fail++;
                $display("FAIL pattern_read[%0d]: got %h expected %h", o, BufferReadResult, m_rdata);
            end
        end
        RequestReadBuffer = 0;
    endtask

    initial begin
        sys_reset = 0; NewRunReset = 0; Pixel_Valid = 0; Pixel_Value = '0;
        Test_Pattern_Select = 0; Gbd_Writing_Ram = 0; RequestReadBuffer = 0;
        ReadBufferOffset = '0;
        model_reset();
        test_reset();
        test_one_block();
        test_handshake();
        test_overflow();
        test_frame();
        test_reset_mid();
        test_pattern();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
